// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
// State encoding, default latency and counter helpers.
package mem_port_arbiter_pkg;

  localparam int LAT_DEF = 2;
  localparam int W_DEF   = 32;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

  function automatic logic [CNT_W-1:0] lat_cnt(input int lat);
    return CNT_W'(lat);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the shared memory.
// master = requesters plus memory model, slave = arbiter.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int W = W_DEF
) ();

  logic         req0;
  logic         req1;
  logic         we0;
  logic         we1;
  logic [W-1:0] addr0;
  logic [W-1:0] addr1;
  logic [W-1:0] wdata0;
  logic [W-1:0] wdata1;
  logic         gnt0;
  logic         gnt1;
  logic         done0;
  logic         done1;
  logic [W-1:0] rdata;
  logic         mem_en;
  logic         mem_we;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;

  modport master (
    output req0, req1, we0, we1,
    output addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, done0, done1, rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  req0, req1, we0, we1,
    input  addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, done0, done1, rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way winner select. Ties alternate on last grant, or always
// go to port 1 when MEM_ARB_DPRIO_EN is defined.
module rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic  i_req0,
  input  logic  i_req1,
  input  port_t i_last,
  output logic  o_valid,
  output port_t o_win
);

  port_t w_tie;

`ifdef MEM_ARB_DPRIO_EN
  logic w_unused_last;
  assign w_unused_last = i_last;
  assign w_tie = PORT1;
`else
  assign w_tie = (i_last == PORT1) ? PORT0 : PORT1;
`endif

  always_comb begin
    o_valid = i_req0 | i_req1;
    o_win   = PORT0;
    unique case (1'b1)
      (i_req0 & i_req1):  o_win = w_tie;
      (i_req0 & ~i_req1): o_win = PORT0;
      (~i_req0 & i_req1): o_win = PORT1;
      default:            o_win = PORT0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for one fixed-latency memory: IDLE -> BUSY -> DONE.
// MEM_ARB_DPRIO_EN selects fixed data-port priority on ties.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LAT = LAT_DEF,
  parameter int W   = W_DEF
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] LAT_C = lat_cnt(LAT);

  state_t           r_state;
  state_t           w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  port_t            r_last;
  port_t            r_win;
  logic             r_we;
  logic [W-1:0]     r_addr;
  logic [W-1:0]     r_wdata;
  logic [W-1:0]     r_rdata;

  logic  w_pick_v;
  port_t w_pick;
  logic  w_go;
  logic  w_first;
  logic  w_last_busy;

  rr_pick2 u_pick (
    .i_req0  (bus.req0),
    .i_req1  (bus.req1),
    .i_last  (r_last),
    .o_valid (w_pick_v),
    .o_win   (w_pick)
  );

  assign w_first     = (r_state == ST_BUSY) && (r_cnt == LAT_C);
  assign w_last_busy = (r_state == ST_BUSY) && (r_cnt == '0);

  always_comb begin
    w_state_nx = r_state;
    w_go       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // rst gates the grant so nothing pulses while held in reset
        if (w_pick_v && !rst) begin
          w_go       = 1'b1;
          w_state_nx = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (r_cnt == '0) w_state_nx = ST_DONE;
      end
      ST_DONE: w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_last  <= PORT1;
      r_win   <= PORT0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_go) begin
        r_cnt  <= LAT_C;
        r_last <= w_pick;
        r_win  <= w_pick;
        if (w_pick == PORT1) begin
          r_we    <= bus.we1;
          r_addr  <= bus.addr1;
          r_wdata <= bus.wdata1;
        end else begin
          r_we    <= bus.we0;
          r_addr  <= bus.addr0;
          r_wdata <= bus.wdata0;
        end
      end else if ((r_state == ST_BUSY) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_last_busy) begin
        r_rdata <= r_we ? '0 : bus.mem_rdata;
      end
    end
  end

  assign bus.gnt0 = w_go && (w_pick == PORT0);
  assign bus.gnt1 = w_go && (w_pick == PORT1);

  assign bus.done0 = (r_state == ST_DONE) && (r_win == PORT0);
  assign bus.done1 = (r_state == ST_DONE) && (r_win == PORT1);
  assign bus.rdata = r_rdata;

  assign bus.mem_en    = w_first;
  assign bus.mem_we    = w_first & r_we;
  assign bus.mem_addr  = w_first ? r_addr : '0;
  assign bus.mem_wdata = w_first ? r_wdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a done-pulse scoreboard.
// Honors MEM_ARB_DPRIO_EN for the tie sequence.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   cycn = 0;
  int   nvec = 0;
  int   nfail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycn <= cycn + 1;

  mem_port_arbiter_if #(.W(32)) b ();
  mem_port_arbiter_if #(.W(32)) b1 ();
  mem_port_arbiter_if #(.W(32)) b15 ();

  mem_port_arbiter #(.LAT(2), .W(32)) u_dut (
    .clk(clk), .rst(rst), .bus(b)
  );
  mem_port_arbiter #(.LAT(1), .W(32)) u_l1 (
    .clk(clk), .rst(rst), .bus(b1)
  );
  mem_port_arbiter #(.LAT(15), .W(32)) u_l15 (
    .clk(clk), .rst(rst), .bus(b15)
  );

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hDEADBFEF;
  endfunction

  // memory model for the LAT=2 instance: data only in its valid cycle
  logic        pv0 = 1'b0, pv1 = 1'b0;
  logic [31:0] pa0 = '0, pa1 = '0;
  always @(posedge clk) begin
    pv0 <= b.mem_en && !b.mem_we;
    pa0 <= b.mem_addr;
    pv1 <= pv0;
    pa1 <= pa0;
  end
  assign b.mem_rdata   = pv1 ? f(pa1) : 32'hBAD0BAD0;
  assign b1.mem_rdata  = 32'hCAFE0001;
  assign b15.mem_rdata = 32'hCAFE000F;

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t q[$];
  exp_t e;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic p, input logic [31:0] d, input int c);
    exp_t x;
    x.port = p;
    x.data = d;
    x.cyc  = c;
    q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {26'd0, b.gnt0, b.gnt1, b.done0, b.done1,
                        b.mem_en, b.mem_we}, 32'd0);
    chk({tag, "_maddr"}, b.mem_addr, 32'd0);
    chk({tag, "_mwdata"}, b.mem_wdata, 32'd0);
    chk({tag, "_rdata"}, b.rdata, 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && (b.done0 || b.done1)) begin
      if (q.size() == 0) begin
        chk("unexp_done", {30'd0, b.done1, b.done0}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("done_port", {30'd0, b.done1, b.done0},
            e.port ? 32'd2 : 32'd1);
        chk("done_rdata", b.rdata, e.data);
        chk("done_cycle", 32'(cycn), 32'(e.cyc));
      end
    end
  end

  int c;
  int d1n, d1c, d15n, d15c;
  logic [31:0] d1r, d15r;
  logic e0, e1;

  initial begin
    rst = 1'b1;
    b.req0 = 0; b.req1 = 0; b.we0 = 0; b.we1 = 0;
    b.addr0 = 0; b.addr1 = 0; b.wdata0 = 0; b.wdata1 = 0;
    b1.req0 = 0; b1.req1 = 0; b1.we0 = 0; b1.we1 = 0;
    b1.addr0 = 0; b1.addr1 = 0; b1.wdata0 = 0; b1.wdata1 = 0;
    b15.req0 = 0; b15.req1 = 0; b15.we0 = 0; b15.we1 = 0;
    b15.addr0 = 0; b15.addr1 = 0; b15.wdata0 = 0; b15.wdata1 = 0;

    // reset with a pending request: no grant may leak out
    step();
    b.req0 = 1; b.addr0 = 32'h100;
    step();
    #1 chk_zero("reset");

    // single read, request dropped after grant
    step();
    rst = 0;
    c = cycn;
    #1 chk("rd_gnt", {30'd0, b.gnt0, b.gnt1}, 32'd2);
    push(1'b0, 32'hDEADBEEF, c + 4);
    step();
    b.req0 = 0; b.addr0 = 32'hFFFF_FFFF;
    #1 chk("rd_men", {30'd0, b.mem_en, b.mem_we}, 32'd2);
    chk("rd_maddr", b.mem_addr, 32'h100);
    chk("rd_gnt_busy", {30'd0, b.gnt0, b.gnt1}, 32'd0);
    step();
    #1 chk("rd_men_off", {31'd0, b.mem_en}, 32'd0);
    step();
    step();
    // request during DONE is ignored, served in the next IDLE
    b.req1 = 1; b.we1 = 1; b.addr1 = 32'h200; b.wdata1 = 32'h12345678;
    #1 chk("done_ignore", {30'd0, b.gnt0, b.gnt1}, 32'd0);

    // write on port 1
    step();
    c = cycn;
    #1 chk("wr_gnt", {30'd0, b.gnt0, b.gnt1}, 32'd1);
    push(1'b1, 32'd0, c + 4);
    step();
    b.req1 = 0; b.we1 = 0; b.addr1 = 32'h0BAD; b.wdata1 = 32'h0BAD;
    #1 chk("wr_men", {30'd0, b.mem_en, b.mem_we}, 32'd3);
    chk("wr_maddr", b.mem_addr, 32'h200);
    chk("wr_mwdata", b.mem_wdata, 32'h12345678);
    repeat (4) step();

    // tie sequence from reset
    rst = 1;
    #1 chk_zero("reset2");
    step();
    rst = 0;
    b.req0 = 1; b.req1 = 1; b.addr0 = 32'h300; b.addr1 = 32'h400;
    c = cycn;
    for (int i = 0; i < 15; i++) begin
      if (i > 0) step();
      if (i == 11) begin
        b.req0 = 0; b.req1 = 0;
      end
      #1;
`ifdef MEM_ARB_DPRIO_EN
      e0 = 1'b0;
      e1 = (i == 0) || (i == 5) || (i == 10);
`else
      e0 = (i == 0) || (i == 10);
      e1 = (i == 5);
`endif
      chk($sformatf("tie_gnt%0d", i), {30'd0, b.gnt0, b.gnt1},
          {30'd0, e0, e1});
      if (e0) push(1'b0, f(32'h300), c + i + 4);
      if (e1) push(1'b1, f(32'h400), c + i + 4);
    end

    // reset in the middle of BUSY abandons the transaction
    step();
    b.req0 = 1; b.addr0 = 32'h500;
    #1 chk("rb_gnt", {30'd0, b.gnt0, b.gnt1}, 32'd2);
    step();
    b.req0 = 0;
    step();
    rst = 1;
    #1 chk_zero("rst_busy");
    step();
    rst = 0;
    repeat (4) step();
    b.req0 = 1; b.addr0 = 32'h600;
    c = cycn;
    #1 chk("post_rst_gnt", {30'd0, b.gnt0, b.gnt1}, 32'd2);
    push(1'b0, f(32'h600), c + 4);
    step();
    b.req0 = 0;
    repeat (4) step();

    // lone read on port 1
    b.req1 = 1; b.addr1 = 32'h800;
    c = cycn;
    #1 chk("p1_gnt", {30'd0, b.gnt0, b.gnt1}, 32'd1);
    push(1'b1, f(32'h800), c + 4);
    step();
    b.req1 = 0;
    repeat (5) step();

    // LAT=1 and LAT=15 instances
    b1.req0 = 1; b1.addr0 = 32'h700;
    b15.req0 = 1; b15.addr0 = 32'h700;
    c = cycn;
    #1 chk("l1_gnt", {31'd0, b1.gnt0}, 32'd1);
    chk("l15_gnt", {31'd0, b15.gnt0}, 32'd1);
    d1n = 0; d15n = 0; d1c = -1; d15c = -1; d1r = 0; d15r = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 1) begin
        b1.req0 = 0; b15.req0 = 0;
      end
      #1;
      if (b1.done0) begin
        d1n++; d1c = cycn; d1r = b1.rdata;
      end
      if (b15.done0) begin
        d15n++; d15c = cycn; d15r = b15.rdata;
      end
    end
    chk("l1_ndone", 32'(d1n), 32'd1);
    chk("l1_lat", 32'(d1c), 32'(c + 3));
    chk("l1_rdata", d1r, 32'hCAFE0001);
    chk("l15_ndone", 32'(d15n), 32'd1);
    chk("l15_lat", 32'(d15c), 32'(c + 17));
    chk("l15_rdata", d15r, 32'hCAFE000F);

    chk("sb_pending", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
